// File: rtl/ptp_tx_gen.sv
// PTP transmit frame generator: arbitrates Sync/Delay_Req/Delay_Resp requests
// and emits fixed 6-word frames on a valid/ready stream with completion reporting.
module ptp_tx_gen #(
  parameter int unsigned SYNC_PERIOD = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_start,
  input  logic        m_or_s,
  input  logic        send_dreq_pkt,
  input  logic        send_dresq_pkt,
  input  logic [63:0] rx_dreq_ts,
  input  logic [11:0] rx_dreq_seq,
  input  logic [63:0] local_time,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready,
  output logic [3:0]  ptp_send_type,
  output logic        ptp_send_type_valid,
  output logic [15:0] drop_cnt
);

  localparam int unsigned TW      = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [TW-1:0] TC    = TW'(SYNC_PERIOD - 1);
  localparam logic [3:0]  T_SYNC  = 4'd1;
  localparam logic [3:0]  T_DREQ  = 4'd3;
  localparam logic [3:0]  T_DRESP = 4'd4;
  localparam logic [15:0] ETH_PTP = 16'h88F7;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_pend_sync, r_pend_dreq, r_pend_dresp;
  logic [63:0]   r_hold_ts;
  logic [11:0]   r_hold_seq;
  logic [11:0]   r_sync_seq, r_dreq_seq;
  logic [15:0]   r_drop_cnt;
  logic [2:0]    r_idx;
  logic [3:0]    r_type;
  logic [31:0]   r_ts_lo;
  logic [63:0]   r_echo_ts;
  logic [11:0]   r_echo_seq;
  logic [31:0]   r_tx_data;
  logic          r_tx_valid, r_tx_sop, r_tx_eop;
  logic [3:0]    r_send_type;
  logic          r_send_valid;

  logic          w_timer_en, w_sync_req, w_idle, w_any, w_hs;
  logic          w_pick_sync, w_pick_dreq, w_pick_dresp;
  logic          w_drop_sync, w_drop_dreq, w_drop_dresp;
  logic [1:0]    w_drop_inc;
  logic [16:0]   w_drop_sum;
  logic [3:0]    w_sel_type;
  logic [11:0]   w_sel_seq;
  logic [63:0]   w_sel_echo_ts;
  logic [11:0]   w_sel_echo_seq;
  logic [31:0]   w_next_word;

  assign tx_data             = r_tx_data;
  assign tx_valid            = r_tx_valid;
  assign tx_sop              = r_tx_sop;
  assign tx_eop              = r_tx_eop;
  assign ptp_send_type       = r_send_type;
  assign ptp_send_type_valid = r_send_valid;
  assign drop_cnt            = r_drop_cnt;

  // Request decode, fixed-priority arbitration and next-word selection
  always_comb begin
    w_timer_en     = sync_start & m_or_s;
    w_sync_req     = w_timer_en & (r_timer == TC);
    w_idle         = (r_state == S_IDLE);
    w_any          = r_pend_sync | r_pend_dreq | r_pend_dresp;
    w_hs           = r_tx_valid & tx_ready;
    w_pick_dresp   = w_idle & r_pend_dresp;
    w_pick_dreq    = w_idle & ~r_pend_dresp & r_pend_dreq;
    w_pick_sync    = w_idle & ~r_pend_dresp & ~r_pend_dreq & r_pend_sync;
    w_drop_sync    = w_sync_req & r_pend_sync;
    w_drop_dreq    = send_dreq_pkt & r_pend_dreq;
    w_drop_dresp   = send_dresq_pkt & r_pend_dresp;
    w_drop_inc     = 2'(w_drop_sync) + 2'(w_drop_dreq) + 2'(w_drop_dresp);
    w_drop_sum     = 17'(r_drop_cnt) + 17'(w_drop_inc);
    w_sel_type     = T_SYNC;
    w_sel_seq      = r_sync_seq;
    w_sel_echo_ts  = 64'h0;
    w_sel_echo_seq = 12'h0;
    if (r_pend_dresp) begin
      w_sel_type     = T_DRESP;
      w_sel_seq      = r_hold_seq;
      w_sel_echo_ts  = r_hold_ts;
      w_sel_echo_seq = r_hold_seq;
    end else if (r_pend_dreq) begin
      w_sel_type = T_DREQ;
      w_sel_seq  = r_dreq_seq;
    end
    case (r_idx)
      3'd0:    w_next_word = local_time[63:32];
      3'd1:    w_next_word = r_ts_lo;
      3'd2:    w_next_word = r_echo_ts[63:32];
      3'd3:    w_next_word = r_echo_ts[31:0];
      3'd4:    w_next_word = {20'h0, r_echo_seq};
      default: w_next_word = 32'h0;
    endcase
  end

  // Sync interval timer, cleared whenever master Sync is not enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (!w_timer_en || r_timer == TC) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Pending flags, DResp holding registers and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_sync  <= 1'b0;
      r_pend_dreq  <= 1'b0;
      r_pend_dresp <= 1'b0;
      r_hold_ts    <= 64'h0;
      r_hold_seq   <= 12'h0;
      r_drop_cnt   <= 16'h0;
    end else begin
      r_pend_sync  <= (r_pend_sync  & ~w_pick_sync)  | w_sync_req;
      r_pend_dreq  <= (r_pend_dreq  & ~w_pick_dreq)  | send_dreq_pkt;
      r_pend_dresp <= (r_pend_dresp & ~w_pick_dresp) | send_dresq_pkt;
      if (send_dresq_pkt && !r_pend_dresp) begin
        r_hold_ts  <= rx_dreq_ts;
        r_hold_seq <= rx_dreq_seq;
      end
      if (w_drop_inc != 2'd0) begin
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  // Frame FSM; echo fields are snapshotted at frame start so a new DResp
  // request cannot corrupt a frame already in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_type       <= 4'd0;
      r_ts_lo      <= 32'h0;
      r_echo_ts    <= 64'h0;
      r_echo_seq   <= 12'h0;
      r_sync_seq   <= 12'h0;
      r_dreq_seq   <= 12'h0;
      r_tx_data    <= 32'h0;
      r_tx_valid   <= 1'b0;
      r_tx_sop     <= 1'b0;
      r_tx_eop     <= 1'b0;
      r_send_type  <= 4'd0;
      r_send_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_SEND;
            r_idx      <= 3'd0;
            r_type     <= w_sel_type;
            r_echo_ts  <= w_sel_echo_ts;
            r_echo_seq <= w_sel_echo_seq;
            r_tx_data  <= {ETH_PTP, w_sel_type, w_sel_seq};
            r_tx_valid <= 1'b1;
            r_tx_sop   <= 1'b1;
            r_tx_eop   <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_tx_sop <= 1'b0;
            if (r_idx == 3'd0) begin
              r_ts_lo <= local_time[31:0];
            end
            if (r_idx == 3'd5) begin
              r_state      <= S_DONE;
              r_tx_valid   <= 1'b0;
              r_tx_eop     <= 1'b0;
              r_tx_data    <= 32'h0;
              r_send_type  <= r_type;
              r_send_valid <= 1'b1;
            end else begin
              r_idx     <= r_idx + 3'd1;
              r_tx_data <= w_next_word;
              r_tx_eop  <= (r_idx == 3'd4);
            end
          end
        end
        S_DONE: begin
          r_send_valid <= 1'b0;
          r_state      <= S_IDLE;
          if (r_type == T_SYNC) begin
            r_sync_seq <= r_sync_seq + 12'd1;
          end else if (r_type == T_DREQ) begin
            r_dreq_seq <= r_dreq_seq + 12'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
